// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential and redirected PC generation, a single
// outstanding instruction-memory request, and a small in-order instruction queue.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redir_valid,
  input  logic [1:0]        redir_mode,
  input  logic [ADDR_W-1:0] redir_pc,
  input  logic [25:0]       jmp_addr,
  input  logic [15:0]       branch_offset,
  input  logic [ADDR_W-1:0] reg_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       q_word [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;

  logic              redir;
  logic              pop;
  logic              push;
  logic [PTR_W:0]    count_after_pop;
  logic [PTR_W:0]    count_next;
  logic              room_after_pop;
  logic              room_after_push;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] link_pc;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] reg_target;
  logic [ADDR_W-1:0] target;

  assign link_pc       = redir_pc + ADDR_W'(4);
  assign branch_target = link_pc + {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};
  assign reg_target    = {reg_addr[ADDR_W-1:2], 2'b00};
  assign seq_pc        = fetch_pc + ADDR_W'(4);

  // Jumps keep the top region bits of the link address; a 28-bit PC has none.
  if (ADDR_W > 28) begin : g_jump_region
    assign jump_target = {link_pc[ADDR_W-1:28], jmp_addr, 2'b00};
  end else begin : g_jump_flat
    assign jump_target = {jmp_addr, 2'b00};
  end

  always_comb begin
    target = fetch_pc;
    case (redir_mode)
      2'd0:    target = jump_target;
      2'd1:    target = branch_target;
      2'd2:    target = reg_target;
      default: target = fetch_pc;
    endcase
  end

  assign redir           = redir_valid && (redir_mode != 2'd3);
  assign instr_valid     = (count != '0);
  assign pop             = instr_valid && instr_ready;
  assign push            = (state == WAIT) && imem_ack && !redir;
  assign count_after_pop = count - (PTR_W+1)'(pop);
  assign count_next      = count_after_pop + (PTR_W+1)'(push);
  assign room_after_pop  = count_after_pop < (PTR_W+1)'(DEPTH);
  assign room_after_push = count_next < (PTR_W+1)'(DEPTH);

  assign imem_req  = (state != IDLE);
  assign imem_addr = req_addr;
  assign instr     = instr_valid ? q_word[rd_ptr] : 32'd0;
  assign instr_pc  = instr_valid ? q_pc[rd_ptr] : '0;

  // A request is only issued when its response is guaranteed a free slot,
  // so the queue never needs an overflow check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (redir) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          q_word[wr_ptr] <= imem_rdata;
          q_pc[wr_ptr]   <= req_addr;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count_next;
      end

      case (state)
        IDLE: begin
          if (redir) begin
            fetch_pc <= target;
            req_addr <= target;
            state    <= WAIT;
          end else if (room_after_pop) begin
            req_addr <= fetch_pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (redir) begin
            fetch_pc <= target;
            if (imem_ack) begin
              req_addr <= target;
            end else begin
              state <= DROP;
            end
          end else if (imem_ack) begin
            fetch_pc <= seq_pc;
            if (room_after_push) begin
              req_addr <= seq_pc;
            end else begin
              state <= IDLE;
            end
          end
        end
        // The stale response still has to be absorbed before refetching.
        DROP: begin
          if (redir) begin
            fetch_pc <= target;
          end
          if (imem_ack) begin
            req_addr <= redir ? target : fetch_pc;
            state    <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// traffic, checked against a program-order instruction stream model.
module tb_fetch_unit;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst;
  logic        redir_valid;
  logic [1:0]  redir_mode;
  logic [31:0] redir_pc;
  logic [25:0] jmp_addr;
  logic [15:0] branch_offset;
  logic [31:0] reg_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          checks    = 0;
  int          failures  = 0;
  int          pops      = 0;
  int          req_age   = 0;
  int          ack_lat   = 1;
  int          p0        = 0;
  bit          rand_mode = 1'b0;
  bit          new_req   = 1'b0;
  logic [31:0] held_addr = 32'h0;
  logic [31:0] exp_pc    = RESET_PC;

  fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .redir_valid   (redir_valid),
    .redir_mode    (redir_mode),
    .redir_pc      (redir_pc),
    .jmp_addr      (jmp_addr),
    .branch_offset (branch_offset),
    .reg_addr      (reg_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] redirect_target(input logic [1:0] mode, input logic [31:0] pc,
                                                  input logic [25:0] j, input logic [15:0] off,
                                                  input logic [31:0] r);
    logic [31:0] nxt;
    logic [31:0] off_ext;
    nxt     = pc + 32'd4;
    off_ext = {{16{off[15]}}, off};
    case (mode)
      2'd0:    return (nxt & 32'hF000_0000) | ({6'd0, j} * 32'd4);
      2'd1:    return nxt + off_ext * 32'd4;
      default: return r & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One clock cycle: memory responder, stream model, then post-edge checks.
  task automatic apply_stimulus(input bit force_ack);
    bit pre_req;
    bit pre_rst;
    bit acked;
    bit redir_eff;
    pre_req = imem_req;
    pre_rst = rst;
    if (imem_req && req_age >= ack_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else if (!imem_req && (force_ack || (rand_mode && $urandom_range(0, 7) == 0))) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
    end
    acked     = imem_req && imem_ack;
    redir_eff = redir_valid && (redir_mode != 2'd3);

    if (pre_rst) begin
      exp_pc = RESET_PC;
    end else if (redir_eff) begin
      exp_pc = redirect_target(redir_mode, redir_pc, jmp_addr, branch_offset, reg_addr);
    end else if (instr_valid && instr_ready) begin
      check_output("pop_pc", instr_pc, exp_pc);
      check_output("pop_word", instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      pops++;
    end

    @(posedge clk);
    #1;
    if (pre_rst || redir_eff) check_output("flush_valid", 32'(instr_valid), 32'd0);
    if (pre_rst) check_output("rst_req", 32'(imem_req), 32'd0);
    if (!instr_valid) begin
      check_output("idle_instr", instr, 32'd0);
      check_output("idle_pc", instr_pc, 32'd0);
    end
    new_req = imem_req && (!pre_req || acked);
    if (imem_req && !new_req) check_output("addr_stable", imem_addr, held_addr);
    if (new_req) begin
      held_addr = imem_addr;
      req_age   = 0;
      if (rand_mode) ack_lat = int'($urandom_range(0, 3));
    end else if (imem_req) begin
      req_age++;
    end else begin
      req_age = 0;
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0);
  endtask

  task automatic wait_new_req(input logic [31:0] exp_addr, input string tag);
    for (int i = 0; i < 50 && !new_req; i++) apply_stimulus(1'b0);
    check_output({tag, "_seen"}, 32'(new_req), 32'd1);
    check_output(tag, imem_addr, exp_addr);
  endtask

  initial begin
    rst           = 1'b1;
    redir_valid   = 1'b0;
    redir_mode    = 2'd0;
    redir_pc      = 32'h0;
    jmp_addr      = 26'h0;
    branch_offset = 16'h0;
    reg_addr      = 32'h0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    instr_ready   = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    run_cycles(3);
    check_output("reset_req", 32'(imem_req), 32'd0);
    check_output("reset_valid", 32'(instr_valid), 32'd0);

    // Streaming with ack one cycle after each request
    rst         = 1'b0;
    instr_ready = 1'b1;
    ack_lat     = 1;
    p0          = pops;
    run_cycles(20);
    check_output("stream_pops", 32'(pops - p0 >= 8), 32'd1);

    // Consumer stalled: queue fills to DEPTH and fetching stops
    instr_ready = 1'b0;
    run_cycles(20);
    check_output("full_req_off", 32'(imem_req), 32'd0);
    check_output("full_head_pc", instr_pc, exp_pc);
    instr_ready = 1'b1;
    apply_stimulus(1'b0);
    check_output("pulse_new_req", 32'(imem_req), 32'd1);
    instr_ready = 1'b0;
    run_cycles(6);
    check_output("refill_req_off", 32'(imem_req), 32'd0);
    ack_lat     = 1000;
    instr_ready = 1'b1;
    p0          = pops;
    run_cycles(8);
    check_output("queued_words", 32'(pops - p0), 32'd4);
    ack_lat = 1;

    // Branch back onto itself
    redir_valid   = 1'b1;
    redir_mode    = 2'd1;
    redir_pc      = 32'h100;
    branch_offset = 16'hFFFF;
    apply_stimulus(1'b0);
    redir_valid = 1'b0;
    check_output("branch_empty", 32'(instr_valid), 32'd0);
    wait_new_req(32'h100, "branch_addr");
    run_cycles(8);

    // Register redirect while the request to 0x20 is outstanding
    rst = 1'b1;
    apply_stimulus(1'b0);
    rst = 1'b0;
    for (int i = 0; i < 100 && !(new_req && imem_addr == 32'h20); i++) apply_stimulus(1'b0);
    check_output("reach_0x20", imem_addr, 32'h20);
    ack_lat     = 3;
    redir_valid = 1'b1;
    redir_mode  = 2'd2;
    reg_addr    = 32'h1003;
    apply_stimulus(1'b0);
    redir_valid = 1'b0;
    check_output("drop_req_held", 32'(imem_req), 32'd1);
    ack_lat = 1;
    wait_new_req(32'h1000, "reg_addr");
    p0 = pops;
    run_cycles(10);
    check_output("reg_stream_pops", 32'(pops - p0 >= 3), 32'd1);

    // Jump into a new region, then a reserved-mode redirect
    redir_valid = 1'b1;
    redir_mode  = 2'd0;
    redir_pc    = 32'h4000_0010;
    jmp_addr    = 26'h40;
    apply_stimulus(1'b0);
    redir_valid = 1'b0;
    wait_new_req(32'h4000_0100, "jump_addr");
    run_cycles(6);
    redir_valid = 1'b1;
    redir_mode  = 2'd3;
    redir_pc    = 32'h0000_0800;
    reg_addr    = 32'h0000_0C00;
    apply_stimulus(1'b0);
    redir_valid = 1'b0;
    p0          = pops;
    run_cycles(10);
    check_output("mode3_stream_pops", 32'(pops - p0 >= 3), 32'd1);

    // Reset during an outstanding request, late ack while idle
    ack_lat = 1000;
    for (int i = 0; i < 20 && !imem_req; i++) apply_stimulus(1'b0);
    check_output("req_before_rst", 32'(imem_req), 32'd1);
    rst = 1'b1;
    apply_stimulus(1'b0);
    rst     = 1'b0;
    ack_lat = 1;
    apply_stimulus(1'b1);
    wait_new_req(RESET_PC, "rst_restart_addr");
    run_cycles(10);

    // Random traffic
    rand_mode = 1'b1;
    p0        = pops;
    for (int i = 0; i < 3000; i++) begin
      instr_ready   = ($urandom_range(0, 9) < 7);
      redir_valid   = ($urandom_range(0, 19) == 0);
      redir_mode    = 2'($urandom_range(0, 3));
      redir_pc      = $urandom;
      jmp_addr      = 26'($urandom);
      branch_offset = 16'($urandom);
      reg_addr      = $urandom;
      rst           = ($urandom_range(0, 299) == 0);
      apply_stimulus(1'b0);
    end
    rst         = 1'b0;
    redir_valid = 1'b0;
    check_output("random_pops", 32'(pops - p0 > 300), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
